fifo_wptr_full: RTL and testbench

- Write-side control stage of the async FIFO. Sits directly upstream of fifo_mem in the write clock domain.
- Accepts push requests, drives the memory write address and write enable, and keeps the binary and Gray write pointers.
- Synchronizes the read-domain Gray pointer into this domain and generates full, almost_full, fill level and a sticky overflow flag.

---
 rtl/fifo_wptr_full.sv | 136 +++++++++++++
 tb/tb_fifo_wptr_full.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wptr_full.sv
// Write-side control stage of the asynchronous FIFO.
// Owns the binary and Gray write pointers and drives the fifo_mem write port.
// Brings the read-domain Gray pointer across with a two-flop synchronizer.
// Derives full, almost_full, a pessimistic fill level and a sticky overflow flag.
module fifo_wptr_full #(
  parameter int ADDR_SIZE = 3,
  parameter int AF_THRESH = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 w_inc,
  input  logic [ADDR_SIZE:0]   r_ptr_gray,
  input  logic                 clr_ovf,
  output logic                 w_en,
  output logic [ADDR_SIZE-1:0] w_addr,
  output logic [ADDR_SIZE:0]   w_ptr_gray,
  output logic                 full,
  output logic                 almost_full,
  output logic [ADDR_SIZE:0]   level,
  output logic                 overflow
);

  // Pointer width: one extra MSB separates "full" from "empty" when the
  // address bits of the two pointers are equal.
  localparam int PW = ADDR_SIZE + 1;

  // The threshold is compared in pointer width so the comparison is unsigned
  // and the widths match; the legal threshold range always fits in PW bits.
  localparam logic [PW-1:0] AF_LIMIT = PW'(AF_THRESH);

  // Gray-to-binary conversion: each binary bit is the XOR of all Gray bits
  // from the MSB down to that position.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b         = '0;
    b[PW-1]   = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] w_bin;
  logic [PW-1:0] w_bin_next;
  logic [PW-1:0] w_gray_next;
  logic [PW-1:0] rq1;
  logic [PW-1:0] rq2;
  logic [PW-1:0] rbin;
  logic [PW-1:0] full_target;
  logic [PW-1:0] level_next;
  logic          full_next;
  logic          af_next;
  logic          ovf_set;

  // A push is only accepted while the registered full flag is low, so the
  // memory is never written when full, even in the cycle before full drops.
  assign w_en   = w_inc & ~full;
  assign w_addr = w_bin[ADDR_SIZE-1:0];

  // Next pointer values; the addition wraps naturally at 2**PW.
  assign w_bin_next  = w_bin + {{ADDR_SIZE{1'b0}}, w_en};
  assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);

  // Read pointer seen from this domain, in binary for the level arithmetic.
  assign rbin = gray2bin(rq2);

  // Full when the next write pointer equals the synchronized read pointer with
  // its top two Gray bits inverted (one full lap ahead). With a single address
  // bit both pointer bits are "top" bits, so the whole pointer is inverted.
  generate
    if (ADDR_SIZE == 1) begin : g_full_narrow
      assign full_target = ~rq2;
    end else begin : g_full_wide
      assign full_target = {~rq2[PW-1:PW-2], rq2[PW-3:0]};
    end
  endgenerate

  // Fill count against the stale read pointer; it can only overstate the
  // fill, which keeps full and almost_full on the safe side.
  assign level_next = w_bin_next - rbin;
  assign full_next  = (w_gray_next == full_target);
  assign af_next    = (level_next >= AF_LIMIT);

  // A push attempted against the registered full flag is an overflow.
  assign ovf_set = w_inc & full;

  // Two-flop synchronizer for the read-domain Gray pointer; only rq2 is used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq1 <= '0;
      rq2 <= '0;
    end else begin
      // NOTE: non-blocking assignments make rq2 take the old rq1, forming a
      // real two-stage chain instead of collapsing into one flop.
      rq1 <= r_ptr_gray;
      rq2 <= rq1;
    end
  end

  // Write pointers; the Gray copy leaves straight from a flop so the read
  // domain never sees a multi-bit glitch during an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_bin      <= '0;
      w_ptr_gray <= '0;
    end else begin
      w_bin      <= w_bin_next;
      w_ptr_gray <= w_gray_next;
    end
  end

  // Registered status flags and fill level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full        <= 1'b0;
      almost_full <= 1'b0;
      level       <= '0;
    end else begin
      full        <= full_next;
      almost_full <= af_next;
      level       <= level_next;
    end
  end

  // Sticky overflow: a new overflow wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full (ADDR_SIZE=3, AF_THRESH=6).
// A count-based model predicts the outputs after each clock edge; the
// expectations are queued when stimulus is driven and popped when sampled.
module tb_fifo_wptr_full;

  localparam int ADDR_SIZE = 3;
  localparam int AF_THRESH = 6;
  localparam int DEPTH     = 1 << ADDR_SIZE;

  typedef struct packed {
    logic       w_en;
    logic [2:0] w_addr;
    logic [3:0] w_ptr_gray;
    logic       full;
    logic       almost_full;
    logic [3:0] level;
    logic       overflow;
  } obs_t;

  logic       clk;
  logic       rst_n;
  logic       w_inc;
  logic [3:0] r_ptr_gray;
  logic       clr_ovf;
  logic       w_en;
  logic [2:0] w_addr;
  logic [3:0] w_ptr_gray;
  logic       full;
  logic       almost_full;
  logic [3:0] level;
  logic       overflow;

  fifo_wptr_full #(
    .ADDR_SIZE (ADDR_SIZE),
    .AF_THRESH (AF_THRESH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .w_inc       (w_inc),
    .r_ptr_gray  (r_ptr_gray),
    .clr_ovf     (clr_ovf),
    .w_en        (w_en),
    .w_addr      (w_addr),
    .w_ptr_gray  (w_ptr_gray),
    .full        (full),
    .almost_full (almost_full),
    .level       (level),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   vectors    = 0;
  int   miscompares = 0;
  obs_t sb[$];

  // Model state, kept as plain counts rather than pointers.
  int   m_wcnt;      // pushes accepted so far
  int   r_cnt;       // reads completed by the (imaginary) read side
  int   m_rd1;       // read count after first synchronizer stage
  int   m_rd2;       // read count after second synchronizer stage
  logic m_full;
  logic m_ovf;

  function automatic logic [3:0] to_gray(input int n);
    logic [3:0] b;
    b = 4'(n % 16);
    return b ^ (b >> 1);
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.w_en        = w_en;
    o.w_addr      = w_addr;
    o.w_ptr_gray  = w_ptr_gray;
    o.full        = full;
    o.almost_full = almost_full;
    o.level       = level;
    o.overflow    = overflow;
    return o;
  endfunction

  task automatic model_reset();
    m_wcnt = 0;
    m_rd1  = 0;
    m_rd2  = 0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
  endtask

  // Drive one cycle of stimulus, queue the predicted post-edge outputs,
  // then wait until just after the edge so the caller can sample.
  task automatic step(input logic inc, input logic clr);
    obs_t e;
    int   lvl;
    logic acc;
    @(negedge clk);
    w_inc      = inc;
    clr_ovf    = clr;
    r_ptr_gray = to_gray(r_cnt);
    acc = inc && !m_full;
    if (inc && m_full)  m_ovf = 1'b1;
    else if (clr)       m_ovf = 1'b0;
    if (acc) m_wcnt++;
    lvl    = m_wcnt - m_rd2;
    m_full = (lvl == DEPTH);
    m_rd2  = m_rd1;
    m_rd1  = r_cnt;
    e.w_en        = inc && !m_full;
    e.w_addr      = 3'(m_wcnt % DEPTH);
    e.w_ptr_gray  = to_gray(m_wcnt);
    e.full        = m_full;
    e.almost_full = (lvl >= AF_THRESH);
    e.level       = 4'(lvl);
    e.overflow    = m_ovf;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, want;
    rst_n = 1'b0; w_inc = 1'b0; clr_ovf = 1'b0; r_cnt = 0; r_ptr_gray = 4'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    want = '0;
    sb.push_back(want);
    got = sample(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL reset_idle: got %h want %h", got, want);
    end
    @(negedge clk); rst_n = 1'b1;
    // Push a few words, then reset asynchronously with w_inc still high.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      got = sample(); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL reset_pre[%0d]: got %h want %h", i, got, want);
      end
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    want      = '0;
    want.w_en = 1'b1;
    sb.push_back(want);
    #1;
    got = sample(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL reset_async: got %h want %h", got, want);
    end
    @(negedge clk); w_inc = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_fill();
    obs_t got, want;
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 1'b0);
      got = sample(); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL fill[%0d]: got %h want %h", i, got, want);
      end
    end
    vectors++;
    if ({full, level, w_ptr_gray} !== {1'b1, 4'd8, 4'b1100}) begin
      miscompares++;
      $display("FAIL fill_end: got full=%b level=%0d gray=%b want 1 8 1100",
               full, level, w_ptr_gray);
    end
  endtask

  task automatic test_overflow();
    obs_t got, want;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0);
      got = sample(); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL ovf_push[%0d]: got %h want %h", i, got, want);
      end
    end
    // Overflowing push together with clear: the set wins.
    step(1'b1, 1'b1);
    got = sample(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL ovf_set_wins: got %h want %h", got, want);
    end
    step(1'b0, 1'b1);
    got = sample(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL ovf_clear: got %h want %h", got, want);
    end
    vectors++;
    if ({overflow, w_ptr_gray} !== {1'b0, 4'b1100}) begin
      miscompares++;
      $display("FAIL ovf_end: got ovf=%b gray=%b want 0 1100", overflow, w_ptr_gray);
    end
  endtask

  task automatic test_drain();
    obs_t got, want;
    r_cnt = 1;
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 1'b0);
      got = sample(); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL drain[%0d]: got %h want %h", i, got, want);
      end
    end
    vectors++;
    if ({full, level} !== {1'b0, 4'd7}) begin
      miscompares++;
      $display("FAIL drain_end: got full=%b level=%0d want 0 7", full, level);
    end
  endtask

  task automatic test_wrap();
    obs_t got, want;
    logic seen_full;
    seen_full = 1'b0;
    @(negedge clk); rst_n = 1'b0; w_inc = 1'b0; clr_ovf = 1'b0;
    r_cnt = 0; r_ptr_gray = 4'd0; model_reset();
    @(negedge clk); rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      r_cnt = (m_wcnt >= 3) ? m_wcnt - 3 : 0;
      step(1'b1, 1'b0);
      got = sample(); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL wrap[%0d]: got %h want %h", i, got, want);
      end
      if (full) seen_full = 1'b1;
    end
    vectors++;
    if ({seen_full, w_ptr_gray, w_addr} !== {1'b0, 4'b0000, 3'd0}) begin
      miscompares++;
      $display("FAIL wrap_end: got seen_full=%b gray=%b addr=%0d want 0 0000 0",
               seen_full, w_ptr_gray, w_addr);
    end
  endtask

  task automatic test_gray();
    obs_t       got, want;
    logic [3:0] prev;
    int         pushes;
    prev   = w_ptr_gray;
    pushes = m_wcnt;
    for (int i = 1; i <= 32; i++) begin
      r_cnt = (m_wcnt >= 3) ? m_wcnt - 3 : 0;
      step(1'b1, 1'b0);
      pushes++;
      got = sample(); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL gray_step[%0d]: got %h want %h", i, got, want);
      end
      vectors++;
      if ($countones(prev ^ w_ptr_gray) != 1 || w_ptr_gray !== to_gray(pushes)) begin
        miscompares++;
        $display("FAIL gray_prop[%0d]: got %b (prev %b) want %b", i, w_ptr_gray,
                 prev, to_gray(pushes));
      end
      prev = w_ptr_gray;
    end
  endtask

  task automatic test_back_to_back();
    obs_t got, want;
    for (int i = 0; i < 120; i++) begin
      if (r_cnt < m_wcnt && $urandom_range(0, 2) != 0) r_cnt++;
      step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 7) == 0));
      got = sample(); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL b2b[%0d]: got %h want %h", i, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_wrap();
    test_gray();
    test_back_to_back();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_left: got %0d entries want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1);
  end

endmodule
